// File: rtl/wb_gpio_irq_if.sv
// rtl/wb_gpio_irq_if.sv - Wishbone slave bus bundle for the GPIO block
interface wb_gpio_irq_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        we;
    logic        ack;

    modport master (
        output adr, dat_w, sel, stb, cyc, we,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, sel, stb, cyc, we,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone GPIO with per-pin direction and sticky edge interrupts
module wb_gpio_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    wb_gpio_irq_if.slave     wb,
    inout  wire [WIDTH-1:0]  gpio_io,
    output logic             intr
);

    typedef logic [WIDTH-1:0] pins_t;

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_OE   = 3'd2;
    localparam logic [2:0] REG_IEN  = 3'd3;
    localparam logic [2:0] REG_POL  = 3'd4;
    localparam logic [2:0] REG_ANY  = 3'd5;
    localparam logic [2:0] REG_PEND = 3'd6;

    pins_t       sync_q [SYNC_STAGES];
    pins_t       in_val;
    pins_t       prev_q;
    pins_t       out_q;
    pins_t       oe_q;
    pins_t       ien_q;
    pins_t       pol_q;
    pins_t       any_q;
    pins_t       pend_q;
    pins_t       rise;
    pins_t       fall;
    pins_t       evt;
    pins_t       pend_clr;
    logic [2:0]  warm_q;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        access;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] lane_mask;
    logic [31:0] wr_data;
    logic [31:0] rd_val;
    logic        unused_adr;

    function automatic logic [31:0] zext(input pins_t v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic pins_t merge(input pins_t old, input logic [31:0] data,
                                    input logic [31:0] mask);
        logic [31:0] r;
        r = (zext(old) & ~mask) | (data & mask);
        return r[WIDTH-1:0];
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_io[i] = oe_q[i] ? out_q[i] : 1'bz;
    end

    assign in_val     = sync_q[SYNC_STAGES-1];
    assign access     = wb.cyc & wb.stb & ~ack_q;
    assign wr         = access & wb.we;
    assign idx        = wb.adr[4:2];
    assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};
    assign lane_mask  = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
    assign wr_data    = wb.dat_w & lane_mask;

    assign rise = in_val & ~prev_q;
    assign fall = ~in_val & prev_q;

    // Edges are ignored until the synchroniser and prev flops hold real pad data.
    always_comb begin
        evt = '0;
        if (warm_q == WARM_DONE) begin
            evt = (any_q & (rise | fall)) | (~any_q & ~pol_q & rise) | (~any_q & pol_q & fall);
        end
    end

    always_comb begin
        pend_clr = '0;
        if (wr && idx == REG_PEND) begin
            pend_clr = wr_data[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_IN:   rd_val = zext(in_val);
            REG_OUT:  rd_val = zext(out_q);
            REG_OE:   rd_val = zext(oe_q);
            REG_IEN:  rd_val = zext(ien_q);
            REG_POL:  rd_val = zext(pol_q);
            REG_ANY:  rd_val = zext(any_q);
            REG_PEND: rd_val = zext(pend_q);
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= gpio_io;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_val;
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            out_q  <= '0;
            oe_q   <= '0;
            ien_q  <= '0;
            pol_q  <= '0;
            any_q  <= '0;
            pend_q <= '0;
        end else begin
            ack_q <= access;
            dat_q <= access ? rd_val : 32'd0;
            if (wr) begin
                case (idx)
                    REG_OUT: out_q <= merge(out_q, wb.dat_w, lane_mask);
                    REG_OE:  oe_q  <= merge(oe_q,  wb.dat_w, lane_mask);
                    REG_IEN: ien_q <= merge(ien_q, wb.dat_w, lane_mask);
                    REG_POL: pol_q <= merge(pol_q, wb.dat_w, lane_mask);
                    REG_ANY: any_q <= merge(any_q, wb.dat_w, lane_mask);
                    default: ;
                endcase
            end
            // A new edge wins over a same-cycle clear.
            pend_q <= (pend_q & ~pend_clr) | evt;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_q;
    assign intr     = |(pend_q & ien_q);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb/tb_wb_gpio_irq.sv - randomized and directed bench for wb_gpio_irq against a behavioural model
module tb_wb_gpio_irq;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit live = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    int          dsel = 0;

    wb_gpio_irq_if b8();
    wb_gpio_irq_if b1();
    wb_gpio_irq_if b32();

    assign b8.adr   = adr;  assign b8.dat_w  = wdat; assign b8.sel  = sel; assign b8.we  = we;
    assign b8.cyc   = cyc & (dsel == 0); assign b8.stb  = stb & (dsel == 0);
    assign b1.adr   = adr;  assign b1.dat_w  = wdat; assign b1.sel  = sel; assign b1.we  = we;
    assign b1.cyc   = cyc & (dsel == 1); assign b1.stb  = stb & (dsel == 1);
    assign b32.adr  = adr;  assign b32.dat_w = wdat; assign b32.sel = sel; assign b32.we = we;
    assign b32.cyc  = cyc & (dsel == 2); assign b32.stb = stb & (dsel == 2);

    wire        ack  = (dsel == 0) ? b8.ack   : (dsel == 1) ? b1.ack   : b32.ack;
    wire [31:0] rdat = (dsel == 0) ? b8.dat_r : (dsel == 1) ? b1.dat_r : b32.dat_r;

    wire [7:0]  g8;
    wire [0:0]  g1;
    wire [31:0] g32;
    wire        intr8;
    wire        intr1;
    wire        intr32;
    logic [7:0] pad_drv = '0;

    // model state
    logic [7:0]  m_out = '0, m_oe = '0, m_ien = '0, m_pol = '0, m_any = '0, m_pend = '0;
    logic [7:0]  m_cur = '0, m_prv = '0;
    logic [7:0]  m_q[$];
    int          m_cyc = 0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign g8[i] = m_oe[i] ? 1'bz : pad_drv[i];
    end
    assign g1  = 1'b0;
    assign g32 = '0;

    wb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .reset(reset), .wb(b8.slave), .gpio_io(g8), .intr(intr8));
    wb_gpio_irq #(.WIDTH(1), .SYNC_STAGES(S)) dut1 (
        .clk(clk), .reset(reset), .wb(b1.slave), .gpio_io(g1), .intr(intr1));
    wb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(S)) dut32 (
        .clk(clk), .reset(reset), .wb(b32.slave), .gpio_io(g32), .intr(intr32));

    always @(posedge clk) begin : model
        logic [7:0] pad_now, evt, clr, wv, rd;
        logic       acc;
        pad_now = (m_oe & m_out) | (~m_oe & pad_drv);
        if (reset) begin
            {m_out, m_oe, m_ien, m_pol, m_any, m_pend, m_cur, m_prv} = '0;
            m_q.delete();
            for (int k = 0; k < S; k++) m_q.push_back(8'h00);
            m_cyc = 0;
            m_ack = 1'b0;
            m_rdata = '0;
        end else begin
            acc = b8.cyc && b8.stb && !m_ack;
            case (b8.adr[4:2])
                3'd0: rd = m_cur;
                3'd1: rd = m_out;
                3'd2: rd = m_oe;
                3'd3: rd = m_ien;
                3'd4: rd = m_pol;
                3'd5: rd = m_any;
                3'd6: rd = m_pend;
                default: rd = 8'h00;
            endcase
            m_rdata = acc ? {24'd0, rd} : 32'd0;
            evt = '0;
            for (int b = 0; b < 8; b++) begin
                if (m_cyc > S) begin
                    if (m_any[b]) evt[b] = (m_cur[b] != m_prv[b]);
                    else if (m_pol[b]) evt[b] = m_prv[b] && !m_cur[b];
                    else evt[b] = m_cur[b] && !m_prv[b];
                end
            end
            clr = '0;
            wv = b8.sel[0] ? b8.dat_w[7:0] : 8'h00;
            if (acc && b8.we && b8.sel[0]) begin
                case (b8.adr[4:2])
                    3'd1: m_out = wv;
                    3'd2: m_oe  = wv;
                    3'd3: m_ien = wv;
                    3'd4: m_pol = wv;
                    3'd5: m_any = wv;
                    3'd6: clr   = wv;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~clr) | evt;
            m_ack = acc;
            m_q.push_back(pad_now);
            void'(m_q.pop_front());
            m_prv = m_cur;
            m_cur = m_q[0];
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check_eq("intr", {31'd0, intr8}, {31'd0, |(m_pend & m_ien)});
            check_eq("ack", {31'd0, b8.ack}, {31'd0, m_ack});
            check_eq("dat_o", b8.dat_r, m_rdata);
            check_eq("pins", {24'd0, g8 & m_oe}, {24'd0, m_out & m_oe});
        end
    end

    task automatic wb_write(input int d, input logic [2:0] r, input logic [31:0] data,
                            input logic [3:0] s);
        int n;
        @(negedge clk);
        dsel = d; adr = {27'd0, r, 2'b00}; wdat = data; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 4);
        check_eq("wr_ack_lat", n, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input int d, input logic [2:0] r, output logic [31:0] data);
        int n;
        @(negedge clk);
        dsel = d; adr = {27'd0, r, 2'b00}; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 4);
        check_eq("rd_ack_lat", n, 1);
        data = rdat;
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int op;
        repeat (2) @(negedge clk);
        live = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (S + 3) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            wb_read(0, 3'(r), d);
            check_eq("rst_reg", d, 32'd0);
        end

        @(negedge clk);
        pad_drv = 8'h01;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (S + 4) @(negedge clk);
        wb_read(0, 3'd6, d);
        check_eq("warm_pend", d, 32'd0);
        check_eq("warm_intr", {31'd0, intr8}, 32'd0);
        wb_read(0, 3'd0, d);
        check_eq("warm_in", d, 32'h01);

        pad_drv = 8'h00;
        wb_write(0, 3'd2, 32'hFF, 4'hF);
        wb_write(0, 3'd1, 32'hA5, 4'hF);
        check_eq("pins_a5", {24'd0, g8}, 32'hA5);
        repeat (S + 1) @(negedge clk);
        wb_read(0, 3'd0, d);
        check_eq("in_a5", d, 32'hA5);
        wb_write(0, 3'd1, 32'hFFFF_FF00, 4'b0001);
        wb_read(0, 3'd1, d);
        check_eq("out_lane0", d, 32'h00);
        wb_write(0, 3'd1, 32'h0000_5A00, 4'b1110);
        wb_read(0, 3'd1, d);
        check_eq("out_lane_off", d, 32'h00);
        wb_write(0, 3'd2, 32'h00, 4'hF);
        repeat (S + 2) @(negedge clk);
        wb_write(0, 3'd6, 32'hFF, 4'hF);

        wb_write(0, 3'd3, 32'h01, 4'hF);
        @(negedge clk);
        pad_drv[0] = 1'b1;
        for (int k = 0; k < S; k++) begin
            @(negedge clk);
            check_eq("intr_early", {31'd0, intr8}, 32'd0);
        end
        @(negedge clk);
        check_eq("intr_lat", {31'd0, intr8}, 32'd1);
        pad_drv[0] = 1'b0;
        repeat (S + 3) @(negedge clk);
        wb_read(0, 3'd6, d);
        check_eq("pend_fall", d, 32'h01);
        wb_write(0, 3'd6, 32'h01, 4'hF);
        check_eq("w1c_intr", {31'd0, intr8}, 32'd0);

        wb_write(0, 3'd3, 32'h00, 4'hF);
        wb_write(0, 3'd5, 32'h08, 4'hF);
        @(negedge clk);
        pad_drv[3] = 1'b1;
        repeat (S + 2) @(negedge clk);
        pad_drv[3] = 1'b0;
        repeat (S + 2) @(negedge clk);
        wb_read(0, 3'd6, d);
        check_eq("any_pend", d, 32'h08);
        check_eq("any_masked", {31'd0, intr8}, 32'd0);
        wb_write(0, 3'd3, 32'h08, 4'hF);
        check_eq("any_intr", {31'd0, intr8}, 32'd1);

        wb_write(0, 3'd6, 32'h08, 4'hF);
        check_eq("clr3", {31'd0, intr8}, 32'd0);
        repeat (2) @(negedge clk);
        pad_drv[3] = 1'b1;
        repeat (S - 1) @(negedge clk);
        wb_write(0, 3'd6, 32'h08, 4'hF);
        wb_read(0, 3'd6, d);
        check_eq("set_wins", d, 32'h08);

        wb_write(0, 3'd1, 32'h3C, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        dsel = 0; adr = 32'h4; wdat = 32'hFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        check_eq("rst_ack", {31'd0, b8.ack}, 32'd0);
        reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (S + 3) @(negedge clk);
        wb_read(0, 3'd1, d);
        check_eq("rst_out", d, 32'h00);
        wb_read(0, 3'd6, d);
        check_eq("rst_pend", d, 32'h00);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                @(negedge clk);
                pad_drv = pad_drv ^ 8'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end else if (op < 6) begin
                wb_write(0, 3'($urandom_range(0, 7)), $urandom, 4'($urandom));
            end else if (op < 8) begin
                wb_read(0, 3'($urandom_range(0, 7)), d);
                check_eq("rnd_rd", d, m_rdata);
            end else begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end

        wb_write(1, 3'd1, 32'hFFFF_FFFF, 4'hF);
        wb_read(1, 3'd1, d);
        check_eq("w1_out", d, 32'h1);
        wb_write(1, 3'd4, 32'hFFFF_FFFF, 4'hF);
        wb_read(1, 3'd4, d);
        check_eq("w1_pol", d, 32'h1);
        wb_read(1, 3'd0, d);
        check_eq("w1_in", d, 32'h0);
        wb_write(2, 3'd3, 32'hFFFF_FFFF, 4'hF);
        wb_read(2, 3'd3, d);
        check_eq("w32_ien", d, 32'hFFFF_FFFF);
        wb_write(2, 3'd5, 32'h1234_5678, 4'b1010);
        wb_read(2, 3'd5, d);
        check_eq("w32_any_lanes", d, 32'h1200_5600);
        wb_write(2, 3'd7, 32'hFFFF_FFFF, 4'hF);
        wb_read(2, 3'd7, d);
        check_eq("w32_hole", d, 32'h0);
        check_eq("w32_intr", {31'd0, intr32}, 32'd0);

        live = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
